// File: rtl/run_host.sv
// run_host: initiator side of the processor req/done run handshake; loads an image, runs, reads results.
// Optional WAIT-cycle counter on o_cyc_count is compiled in when RUN_HOST_CYCCNT_EN is defined.
//   state   | meaning
//   S_IDLE  | waiting for start, busy low
//   S_LOAD  | streaming input bytes into data memory
//   S_START | one-cycle req pulse, timer cleared
//   S_WAIT  | waiting for a done rising edge or timeout
//   S_READ  | streaming the result window out of data memory
//   S_FIN   | one busy cycle before returning to idle
module run_host #(
    parameter int unsigned LD_BASE = 0,
    parameter int unsigned LD_CNT  = 64,
    parameter int unsigned RD_BASE = 64,
    parameter int unsigned RD_CNT  = 32,
    parameter int unsigned TMO     = 4000,
    parameter int unsigned TMO_W   = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    output logic        o_busy,
    input  logic        i_in_valid,
    input  logic [7:0]  i_in_data,
    output logic        o_in_ready,
    output logic        o_mem_wr_en,
    output logic [7:0]  o_mem_addr,
    output logic [7:0]  o_mem_wdata,
    input  logic [7:0]  i_mem_rdata,
    output logic        o_req,
    input  logic        i_done,
    output logic        o_out_valid,
    output logic [7:0]  o_out_data,
    input  logic        i_out_ready,
    output logic [1:0]  o_status
`ifdef RUN_HOST_CYCCNT_EN
    ,
    output logic [15:0] o_cyc_count
`endif
);

    localparam int unsigned CNT_W = 16;

    localparam logic [CNT_W-1:0] LD_LAST   = (LD_CNT == 0) ? '0 : CNT_W'(LD_CNT - 1);
    localparam logic [CNT_W-1:0] RD_LAST   = (RD_CNT == 0) ? '0 : CNT_W'(RD_CNT - 1);
    localparam logic [7:0]       LD_BASE_A = 8'(LD_BASE);
    localparam logic [7:0]       RD_BASE_A = 8'(RD_BASE);
    localparam logic [TMO_W:0]   TMO_V     = (TMO_W + 1)'(TMO);

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_OK   = 2'b01;
    localparam logic [1:0] ST_TMO  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_READ,
        S_FIN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [TMO_W-1:0]   r_timer;
    logic [TMO_W-1:0]   w_timer_nxt;
    logic [1:0]         r_status;
    logic [1:0]         w_status_nxt;
    logic               r_done_q;
    logic               w_done_edge;
    logic [TMO_W:0]     w_timer_inc;
    logic               w_tmo_hit;

    assign w_done_edge = i_done & ~r_done_q;
    // Timer value after this WAIT cycle equals the number of WAIT cycles elapsed.
    assign w_timer_inc = {1'b0, r_timer} + (TMO_W + 1)'(1);
    assign w_tmo_hit   = (w_timer_inc >= TMO_V);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_timer  <= '0;
            r_status <= ST_NONE;
            r_done_q <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_timer  <= w_timer_nxt;
            r_status <= w_status_nxt;
            r_done_q <= i_done;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_timer_nxt  = r_timer;
        w_status_nxt = r_status;
        o_in_ready   = 1'b0;
        o_mem_wr_en  = 1'b0;
        o_mem_addr   = 8'h00;
        o_mem_wdata  = 8'h00;
        o_req        = 1'b0;
        o_out_valid  = 1'b0;
        o_out_data   = 8'h00;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_cnt_nxt    = '0;
                    w_status_nxt = ST_NONE;
                    w_state_nxt  = (LD_CNT == 0) ? S_START : S_LOAD;
                end
            end

            S_LOAD: begin
                o_in_ready  = 1'b1;
                o_mem_wr_en = i_in_valid;
                o_mem_addr  = LD_BASE_A + r_cnt[7:0];
                o_mem_wdata = i_in_data;
                if (i_in_valid) begin
                    if (r_cnt == LD_LAST) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_START;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end

            S_START: begin
                o_req       = 1'b1;
                w_timer_nxt = '0;
                w_state_nxt = S_WAIT;
            end

            S_WAIT: begin
                w_timer_nxt = w_timer_inc[TMO_W-1:0];
                // A completion edge takes priority over a simultaneous timeout.
                if (w_done_edge) begin
                    w_cnt_nxt = '0;
                    if (RD_CNT == 0) begin
                        w_status_nxt = ST_OK;
                        w_state_nxt  = S_FIN;
                    end else begin
                        w_state_nxt = S_READ;
                    end
                end else if (w_tmo_hit) begin
                    w_status_nxt = ST_TMO;
                    w_state_nxt  = S_FIN;
                end
            end

            S_READ: begin
                o_out_valid = 1'b1;
                o_mem_addr  = RD_BASE_A + r_cnt[7:0];
                o_out_data  = i_mem_rdata;
                if (i_out_ready) begin
                    if (r_cnt == RD_LAST) begin
                        w_cnt_nxt    = '0;
                        w_status_nxt = ST_OK;
                        w_state_nxt  = S_FIN;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end

            S_FIN: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_busy   = (r_state != S_IDLE);
    assign o_status = r_status;

`ifdef RUN_HOST_CYCCNT_EN
    logic [15:0] r_cyc_count;

    // Cleared at the req pulse, counts WAIT cycles, then holds until the next run.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cyc_count <= '0;
        end else if (r_state == S_START) begin
            r_cyc_count <= '0;
        end else if ((r_state == S_WAIT) && (r_cyc_count != 16'hFFFF)) begin
            r_cyc_count <= r_cyc_count + 16'd1;
        end
    end

    assign o_cyc_count = r_cyc_count;
`endif

endmodule

// File: tb/tb_run_host.sv
// tb_run_host: directed bench for run_host using three instances with different count/timeout parameters.
// Shared byte memory model; cyc_count checks are active when RUN_HOST_CYCCNT_EN is defined.
module tb_run_host;

    logic        clk;
    logic        rst_n;
    logic [2:0]  start;
    logic [2:0]  busy;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [2:0]  in_ready;
    logic [2:0]  wr_en;
    logic [7:0]  addr  [3];
    logic [7:0]  wdata [3];
    logic [7:0]  rdata [3];
    logic [2:0]  req;
    logic        done;
    logic [2:0]  out_valid;
    logic [7:0]  out_data [3];
    logic        out_ready;
    logic [1:0]  status [3];
`ifdef RUN_HOST_CYCCNT_EN
    logic [15:0] cyc [3];
`endif

    int n_pass;
    int n_total;

    bit [7:0]   mem [256];
    bit [255:0] wflag;

    logic       ld_v [5];
    logic [7:0] ld_d [5];
    logic [7:0] ld_a [5];
    logic [7:0] rd_a [8];
    logic [7:0] rd_d [8];
    int         j;

    // A: normal run with gap-load and wrapping read window
    run_host #(.LD_BASE(0), .LD_CNT(4), .RD_BASE(250), .RD_CNT(8), .TMO(200), .TMO_W(16)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .o_busy(busy[0]),
        .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready[0]),
        .o_mem_wr_en(wr_en[0]), .o_mem_addr(addr[0]), .o_mem_wdata(wdata[0]), .i_mem_rdata(rdata[0]),
        .o_req(req[0]), .i_done(done), .o_out_valid(out_valid[0]), .o_out_data(out_data[0]),
        .i_out_ready(out_ready), .o_status(status[0])
`ifdef RUN_HOST_CYCCNT_EN
        , .o_cyc_count(cyc[0])
`endif
    );

    // B: reset mid-load and timeout
    run_host #(.LD_BASE(0), .LD_CNT(8), .RD_BASE(64), .RD_CNT(8), .TMO(50), .TMO_W(16)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .o_busy(busy[1]),
        .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready[1]),
        .o_mem_wr_en(wr_en[1]), .o_mem_addr(addr[1]), .o_mem_wdata(wdata[1]), .i_mem_rdata(rdata[1]),
        .o_req(req[1]), .i_done(done), .o_out_valid(out_valid[1]), .o_out_data(out_data[1]),
        .i_out_ready(out_ready), .o_status(status[1])
`ifdef RUN_HOST_CYCCNT_EN
        , .o_cyc_count(cyc[1])
`endif
    );

    // C: zero-length load and read
    run_host #(.LD_BASE(0), .LD_CNT(0), .RD_BASE(0), .RD_CNT(0), .TMO(50), .TMO_W(16)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start[2]), .o_busy(busy[2]),
        .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready[2]),
        .o_mem_wr_en(wr_en[2]), .o_mem_addr(addr[2]), .o_mem_wdata(wdata[2]), .i_mem_rdata(rdata[2]),
        .o_req(req[2]), .i_done(done), .o_out_valid(out_valid[2]), .o_out_data(out_data[2]),
        .i_out_ready(out_ready), .o_status(status[2])
`ifdef RUN_HOST_CYCCNT_EN
        , .o_cyc_count(cyc[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten locations read back as the inverted address.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (wr_en[k]) begin
                mem[addr[k]]   <= wdata[k];
                wflag[addr[k]] <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_rd
        assign rdata[g] = wflag[addr[g]] ? mem[addr[g]] : ~addr[g];
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        start     = 3'b000;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        done      = 1'b0;
        ld_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        ld_d = '{8'h11, 8'h22, 8'h00, 8'h33, 8'h44};
        ld_a = '{8'd0, 8'd1, 8'd2, 8'd2, 8'd3};
        rd_a = '{8'd250, 8'd251, 8'd252, 8'd253, 8'd254, 8'd255, 8'd0, 8'd1};
        rd_d = '{8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h11, 8'h22};

        // reset state
        cyc(); #1;
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_req", 16'(req), 16'd0);
        chk("rst_in_ready", 16'(in_ready), 16'd0);
        chk("rst_wr_en", 16'(wr_en), 16'd0);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_status_a", 16'(status[0]), 16'd0);
        chk("rst_addr_a", 16'(addr[0]), 16'd0);
        rst_n = 1'b1;
        cyc(); cyc();

        // B: reset while in LOAD with cnt=5
        start[1] = 1'b1;
        cyc(); start[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hB0 + 8'(i);
            #1;
            chk("ldB_wr_en", 16'(wr_en[1]), 16'd1);
            chk("ldB_addr", 16'(addr[1]), 16'(i));
            cyc();
        end
        in_valid = 1'b0;
        #1;
        chk("ldB_stall_wr", 16'(wr_en[1]), 16'd0);
        chk("ldB_stall_addr", 16'(addr[1]), 16'd5);
        chk("ldB_busy", 16'(busy[1]), 16'd1);
        rst_n = 1'b0;
        #1;
        chk("rstB_busy", 16'(busy[1]), 16'd0);
        chk("rstB_in_ready", 16'(in_ready[1]), 16'd0);
        cyc(); #1;
        chk("rstB_busy_next", 16'(busy[1]), 16'd0);
        chk("rstB_in_ready_next", 16'(in_ready[1]), 16'd0);
        chk("rstB_status", 16'(status[1]), 16'd0);
        rst_n = 1'b1;
        cyc();

        // B: done held high before START, never toggles -> timeout after 50 WAIT cycles
        done = 1'b1;
        cyc(); start[1] = 1'b1;
        cyc(); start[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hC0 + 8'(i);
            #1;
            chk("toB_wdata", 16'(wdata[1]), 16'(8'hC0 + 8'(i)));
            chk("toB_addr", 16'(addr[1]), 16'(i));
            cyc();
        end
        in_valid = 1'b0;
        #1;
        chk("toB_req", 16'(req[1]), 16'd1);
        for (int k = 1; k <= 50; k++) begin
            cyc(); #1;
            chk("toB_wait_req", 16'(req[1]), 16'd0);
            chk("toB_wait_status", 16'(status[1]), 16'd0);
            chk("toB_wait_busy", 16'(busy[1]), 16'd1);
        end
        cyc(); #1;
        chk("toB_fin_status", 16'(status[1]), 16'd2);
        chk("toB_fin_busy", 16'(busy[1]), 16'd1);
        chk("toB_fin_out_valid", 16'(out_valid[1]), 16'd0);
`ifdef RUN_HOST_CYCCNT_EN
        chk("toB_cyc_count", cyc[1], 16'd50);
`endif
        cyc(); #1;
        chk("toB_idle_busy", 16'(busy[1]), 16'd0);
        chk("toB_idle_status", 16'(status[1]), 16'd2);
        chk("toB_idle_out_valid", 16'(out_valid[1]), 16'd0);
        done = 1'b0;
        cyc(); cyc();

        // A: load with one gap, done rises 120 cycles after req, stray start in WAIT
        start[0] = 1'b1;
        cyc(); start[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = ld_v[i];
            in_data  = ld_d[i];
            #1;
            chk("ldA_in_ready", 16'(in_ready[0]), 16'd1);
            chk("ldA_wr_en", 16'(wr_en[0]), 16'(ld_v[i]));
            chk("ldA_addr", 16'(addr[0]), 16'(ld_a[i]));
            chk("ldA_wdata", 16'(wdata[0]), 16'(ld_d[i]));
            cyc();
        end
        in_valid = 1'b0;
        #1;
        chk("runA_req", 16'(req[0]), 16'd1);
        chk("runA_start_in_ready", 16'(in_ready[0]), 16'd0);
        for (int k = 1; k <= 120; k++) begin
            cyc();
            start[0] = (k == 10);
            done     = (k == 120);
            #1;
            chk("runA_wait_req", 16'(req[0]), 16'd0);
            chk("runA_wait_busy", 16'(busy[0]), 16'd1);
            chk("runA_wait_out_valid", 16'(out_valid[0]), 16'd0);
        end
        start[0] = 1'b0;
        j = 0;
        for (int c = 0; c < 16; c++) begin
            cyc();
            out_ready = c[0];
            #1;
            chk("rdA_out_valid", 16'(out_valid[0]), 16'd1);
            chk("rdA_addr", 16'(addr[0]), 16'(rd_a[j]));
            chk("rdA_data", 16'(out_data[0]), 16'(rd_d[j]));
            chk("rdA_status", 16'(status[0]), 16'd0);
            if (out_ready) j++;
        end
        cyc();
        out_ready = 1'b0;
        #1;
        chk("runA_fin_status", 16'(status[0]), 16'd1);
        chk("runA_fin_busy", 16'(busy[0]), 16'd1);
        chk("runA_fin_out_valid", 16'(out_valid[0]), 16'd0);
        chk("runA_fin_addr", 16'(addr[0]), 16'd0);
`ifdef RUN_HOST_CYCCNT_EN
        chk("runA_cyc_count", cyc[0], 16'd120);
`endif
        done = 1'b0;
        cyc(); #1;
        chk("runA_idle_busy", 16'(busy[0]), 16'd0);
        chk("runA_idle_status", 16'(status[0]), 16'd1);
        cyc(); #1;
        chk("runA_stray_start_ignored", 16'(busy[0]), 16'd0);

        // C: zero-count run IDLE -> START -> WAIT -> FIN
        cyc(); start[2] = 1'b1;
        cyc(); start[2] = 1'b0;
        #1;
        chk("zC_start_req", 16'(req[2]), 16'd1);
        chk("zC_start_busy", 16'(busy[2]), 16'd1);
        chk("zC_start_in_ready", 16'(in_ready[2]), 16'd0);
        cyc();
        done = 1'b1;
        #1;
        chk("zC_wait_req", 16'(req[2]), 16'd0);
        chk("zC_wait_busy", 16'(busy[2]), 16'd1);
        chk("zC_wait_status", 16'(status[2]), 16'd0);
        cyc(); #1;
        chk("zC_fin_busy", 16'(busy[2]), 16'd1);
        chk("zC_fin_status", 16'(status[2]), 16'd1);
        chk("zC_fin_out_valid", 16'(out_valid[2]), 16'd0);
`ifdef RUN_HOST_CYCCNT_EN
        chk("zC_cyc_count", cyc[2], 16'd1);
`endif
        cyc(); #1;
        chk("zC_idle_busy", 16'(busy[2]), 16'd0);
        chk("zC_idle_status", 16'(status[2]), 16'd1);
        done = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
